// File: rtl/muldiv_pkg.sv
// muldiv_pkg: encodings shared by the HI/LO multiply/divide sequencer and ALU_Control
package muldiv_pkg;
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIX} state_t;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    function automatic logic is_div(input op_t o);
        return o[1];
    endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand capture, radix-2 shift-add / restoring-divide engine and sign fix-up
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             prep,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             dbz,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    op_t                op_r;
    logic [WIDTH-1:0]   rs_r, rt_r, acc_hi, acc_lo, mcand, mag_a, mag_b;
    logic [WIDTH:0]     add_a, add_b, sum;
    logic [2*WIDTH-1:0] prod;
    logic               neg_hi, neg_lo, sub, sa, sb;

    // operand signs (signed ops only) and magnitudes used by the LOAD step
    always_comb begin
        sa    = op_r[0] & rs_r[WIDTH-1];
        sb    = op_r[0] & rt_r[WIDTH-1];
        mag_a = sa ? -rs_r : rs_r;
        mag_b = sb ? -rt_r : rt_r;
    end

    // shared adder: add-if-lsb for multiply, trial subtract of shifted remainder for divide
    always_comb begin
        sub   = is_div(op_r);
        add_a = sub ? {acc_hi, acc_lo[WIDTH-1]} : {1'b0, acc_hi};
        add_b = (sub | acc_lo[0]) ? {1'b0, mcand} : '0;
        sum   = add_a + (sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, sub};
    end

    // final result with sign correction; divide-by-zero bypasses the engine entirely
    always_comb begin
        prod   = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        res_lo = dbz ? '1 : is_div(op_r) ? (neg_lo ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
        res_hi = dbz ? rs_r : is_div(op_r) ? (neg_hi ? -acc_hi : acc_hi) : prod[2*WIDTH-1:WIDTH];
    end

    // capture on accept, set up magnitudes in LOAD, iterate once per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= OP_MULTU;
            rs_r   <= '0;
            rt_r   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            mcand  <= '0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            dbz    <= 1'b0;
        end else if (capture) begin
            op_r <= op_t'(op);
            rs_r <= rs_val;
            rt_r <= rt_val;
            dbz  <= 1'b0;
        end else if (prep) begin
            acc_hi <= '0;
            acc_lo <= is_div(op_r) ? mag_a : mag_b;
            mcand  <= is_div(op_r) ? mag_b : mag_a;
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            dbz    <= is_div(op_r) & (rt_r == '0);
        end else if (step) begin
            if (is_div(op_r)) begin
                acc_hi <= sum[WIDTH] ? add_a[WIDTH-1:0] : sum[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], ~sum[WIDTH]};
            end else begin
                acc_hi <= sum[WIDTH:1];
                acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle mult/div sequencer owning the HI/LO registers
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             capture, prep, step, fix;
    logic [WIDTH-1:0] res_hi, res_lo;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next state: RUN lasts exactly WIDTH cycles, leaving as the counter steps 1 -> 0
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_nx = S_RUN;
            S_RUN:   state_nx = (cnt == CNT_W'(1)) ? S_FIX : S_RUN;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // per-state controls; busy covers LOAD, RUN and FIX
    always_comb begin
        capture = (state == S_IDLE) && start;
        prep    = state == S_LOAD;
        step    = state == S_RUN;
        fix     = state == S_FIX;
        busy    = state != S_IDLE;
    end

    // iteration counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (prep) cnt <= CNT_W'(WIDTH);
        else if (step) cnt <= cnt - CNT_W'(1);
    end

    // HI/LO ownership: results land in FIX; mthi/mtlo only in IDLE and lose to start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix;
            if (fix) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if ((state == S_IDLE) && !start) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture),
        .prep    (prep),
        .step    (step),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .dbz     (div_by_zero),
        .res_hi  (res_hi),
        .res_lo  (res_lo)
    );
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench with an arithmetic reference model
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0, rt_val = '0, wdata = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
    logic [31:0] hi_m = '0, lo_m = '0;
    int          errors = 0, checks = 0, cyc = 0, bcnt = 0;
    exp_t        q[$];

    muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // MIPS semantics from plain 64-bit arithmetic; SV division truncates toward zero like MIPS
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        e.cyc = 0;
        if (o[1] && b == 32'd0) begin
            e.dbz = 1'b1;
            e.lo  = 32'hFFFF_FFFF;
            e.hi  = a;
        end else if (o == OP_MULTU) begin
            p = {32'b0, a} * {32'b0, b};
            {e.hi, e.lo} = p;
        end else if (o == OP_MULT) begin
            p = 64'(sa * sb);
            {e.hi, e.lo} = p;
        end else if (o == OP_DIVU) begin
            e.lo = a / b;
            e.hi = a % b;
        end else begin
            e.lo = 32'(sa / sb);
            e.hi = 32'(sa % sb);
        end
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'b0, busy}, 32'd0);
    endtask

    task automatic wr(input logic h, input logic l, input logic [31:0] d);
        wait_idle();
        hi_we = h;
        lo_we = l;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (h) hi_m = d;
        if (l) lo_m = d;
        check("mt_hi", hi, hi_m);
        check("mt_lo", lo, lo_m);
    endtask

    // mid: pulse hi_we/lo_we during RUN; same: raise lo_we together with start
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic mid, input logic same);
        exp_t        e;
        logic [31:0] old_hi, old_lo;
        wait_idle();
        e      = model(o, a, b);
        e.cyc  = cyc + 35;
        old_hi = hi_m;
        old_lo = lo_m;
        op     = o;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        lo_we  = same;
        wdata  = 32'hDEAD_BEEF;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        lo_we = 1'b0;
        hi_m  = e.hi;
        lo_m  = e.lo;
        check("dbz_clear", {31'b0, div_by_zero}, 32'd0);
        check("busy_on", {31'b0, busy}, 32'd1);
        if (same) check("lo_drop", lo, old_lo);
        if (mid) begin
            repeat (6) @(negedge clk);
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'h1234_5678;
            @(negedge clk);
            hi_we = 1'b0;
            lo_we = 1'b0;
            check("hi_hold", hi, old_hi);
            check("lo_hold", lo, old_lo);
        end
    endtask

    // monitor: pop expected result whenever done is presented
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bcnt = 0;
        end else begin
            check("busy_done_excl", {31'b0, busy & done}, 32'd0);
            if (busy) bcnt++;
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("res_hi", hi, e.hi);
                    check("res_lo", lo, e.lo);
                    check("res_dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
                    check("done_cycle", cyc, e.cyc);
                    check("busy_len", bcnt, 32'd34);
                end
                bcnt = 0;
            end
        end
    end

    initial begin
        #2;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OP_MULT,  32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        issue(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        issue(OP_DIVU,  32'd100, 32'd7, 1'b0, 1'b0);
        issue(OP_DIVU,  32'h1234_5678, 32'd0, 1'b0, 1'b0);
        issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(OP_DIV,   32'h0000_0009, 32'd0, 1'b0, 1'b0);
        wr(1'b1, 1'b0, 32'hA5A5_A5A5);
        issue(OP_MULT,  32'd2, 32'd3, 1'b1, 1'b0);
        issue(OP_MULTU, 32'd5, 32'd9, 1'b0, 1'b1);
        wr(1'b1, 1'b1, 32'h0F0F_0F0F);

        wr(1'b1, 1'b0, 32'h55);
        issue(OP_MULT, $urandom(), $urandom(), 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        q.delete();
        hi_m = '0;
        lo_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(OP_DIVU, 32'd1000, 32'd33, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
            issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b0, $urandom_range(0, 5) == 0);
        end

        begin
            int n = 0;
            while (q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
